pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: fetch-to-decode pipeline register with valid/ready handshakes.
// Flush discards every held instruction. Whenever out_valid is low, out_instr
// reads as the bubble instruction NOP_INSTR.
// Optional build macro PIPE_STAGE_REG_SKID_EN adds one skid entry. With it,
// in_ready comes from state only, so no combinational path runs from
// out_ready to in_ready. Without it, the stage holds a single entry and
// in_ready follows out_ready combinationally.
module pipe_stage_reg #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_instr
);

  logic              main_valid;
  logic [ADDR_W-1:0] main_addr;
  logic [DATA_W-1:0] main_instr;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_addr  = main_addr;
  // When the stage is empty, decode sees a bubble even if stale payload bits remain.
  assign out_instr = main_valid ? main_instr : NOP_INSTR;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic              skid_valid;
  logic [ADDR_W-1:0] skid_addr;
  logic [DATA_W-1:0] skid_instr;

  // in_ready depends only on the skid flop and reset.
  // This keeps out_ready out of the upstream timing path.
  assign in_ready = !rst && !skid_valid;

  // Main register refills from skid first to keep acceptance order; skid catches overflow under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_addr  <= '0;
      main_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_xfer) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_addr  <= skid_addr;
        main_instr <= skid_instr;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_addr  <= in_addr;
        main_instr <= in_instr;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_addr  <= in_addr;
      skid_instr <= in_instr;
    end
  end

`else

  // A single-entry stage can accept new input when it is empty or draining this cycle.
  assign in_ready = !rst && (!main_valid || out_ready);

  // Load on accept, which covers replace-on-drain.
  // Clear on a drain that has no refill.
  // out_addr keeps its last value when the stage empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_addr  <= '0;
      main_instr <= NOP_INSTR;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_addr  <= in_addr;
      main_instr <= in_instr;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// A queue model predicts the outputs and is compared every cycle.
// Directed literal checks pin the model down.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_instr;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: FIFO of held entries ----------------
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] last_a;

  function automatic int cap_free(bit ordy);
    if (rst) return 0;
    if (SKID) return (q.size() < 2) ? 1 : 0;
    return (q.size() == 0 || ordy) ? 1 : 0;
  endfunction

  function automatic logic [31:0] exp_addr();
    return (q.size() > 0) ? q[0].a : last_a;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (q.size() > 0) ? q[0].d : NOP;
  endfunction

  task automatic model_reset();
    q.delete();
    last_a = '0;
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && (cap_free(out_ready) == 1);
    if (flush) begin
      last_a = exp_addr();
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) begin
        last_a = q[0].a;
        void'(q.pop_front());
      end
      if (acc) q.push_back('{in_addr, in_instr});
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_out_addr",  out_addr,  exp_addr());
      chk("m_out_instr", out_instr, exp_instr());
      chk("m_in_ready",  32'(in_ready), 32'(cap_free(out_ready)));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(bit iv, logic [31:0] a, logic [31:0] d, bit ordy, bit fl);
    in_valid  = iv;
    in_addr   = a;
    in_instr  = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr",  out_addr, 32'h0);
    chk("rst_out_instr", out_instr, 32'h00000013);
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Streaming.
    drive(1, 32'h0, 32'h11111111, 1, 0);
    chk("stream0_valid", 32'(out_valid), 32'd1);
    chk("stream0_addr", out_addr, 32'h0);
    drive(1, 32'h4, 32'h22222222, 1, 0);
    chk("stream1_addr", out_addr, 32'h4);
    drive(1, 32'h8, 32'h33333333, 1, 0);
    chk("stream2_addr", out_addr, 32'h8);
    chk("stream2_instr", out_instr, 32'h33333333);

    // Backpressure.
    drive(1, 32'h100, 32'h00500093, 1, 0);
    chk("bp_addr", out_addr, 32'h100);
    in_valid = 1; in_addr = 32'h104; in_instr = 32'h00600113; out_ready = 0;
    #1;
    chk("bp_in_ready0", 32'(in_ready), SKID ? 32'd1 : 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h104, 32'h00600113, 0, 0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_addr", out_addr, 32'h100);
      chk("bp_hold_instr", out_instr, 32'h00500093);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    chk("bp_drain_valid", 32'(out_valid), SKID ? 32'd1 : 32'd0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    // Flush with one entry held and 0x200 presented.
    drive(1, 32'h1F0, 32'h00700193, 0, 0);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    drive(1, 32'h200, 32'h00800213, 0, 1);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_instr", out_instr, 32'h00000013);
    chk("fl_addr_hold", out_addr, 32'h1F0);
    drive(0, 32'h0, 32'h0, 1, 0);
    chk("fl_post_valid", 32'(out_valid), 32'd0);
    chk("fl_post_addr", out_addr, 32'h1F0);

    // Simultaneous input and output transfer on a full stage.
    drive(1, 32'h2F0, 32'h00900293, 1, 0);
    chk("sim_pre_addr", out_addr, 32'h2F0);
    drive(1, 32'h300, 32'h00a00313, 1, 0);
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_addr", out_addr, 32'h300);
    chk("sim_instr", out_instr, 32'h00a00313);

    // Asynchronous reset mid-stream.
    in_valid = 0; out_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", out_addr, 32'h0);
    chk("arst_instr", out_instr, 32'h00000013);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("arst_rel_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Random traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom,
            ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
